bsg_axil_rxs: RTL and testbench



---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 12 +
 rtl/bsg_axil_rxs_decode.sv | 24 ++
 rtl/bsg_axil_rxs.sv | 85 ++++++++
 tb/tb_bsg_axil_rxs.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// bsg_manycore_link_to_axil_pkg: shared AXI-Lite slot map, register offsets and read FSM states.
package bsg_manycore_link_to_axil_pkg;
  localparam int axil_base_addr_width_gp = 12;
  localparam int axil_slot_idx_width_gp = 32 - axil_base_addr_width_gp;
  localparam logic [31:0] axil_m_slot_addr_gp = 32'h1000;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_isr_gp = 12'h000;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_rdfo_gp = 12'h01C;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_rdfd_gp = 12'h020;
  localparam logic [axil_base_addr_width_gp-1:0] axil_s2mm_ofs_rlr_gp = 12'h024;
  typedef enum logic [1:0] {E_RD_IDLE, E_RD_ADDR, E_RD_DATA, E_RD_RESP} rd_state_e;
  typedef enum logic [2:0] {E_OFS_ISR, E_OFS_RDFO, E_OFS_RDFD, E_OFS_RLR, E_OFS_NONE} rd_ofs_e;
endpackage

// File: rtl/bsg_axil_rxs_decode.sv
// bsg_axil_rxs_decode: one-hot slot hit and register offset select for a read address.
module bsg_axil_rxs_decode
  import bsg_manycore_link_to_axil_pkg::*;
#(parameter int num_fifos_p = 0)
(
  input  logic [31:0]            addr_i,
  output logic [num_fifos_p-1:0] hit_o,
  output rd_ofs_e                ofs_o
);
  localparam logic [axil_slot_idx_width_gp-1:0] base_slot_lp =
    axil_slot_idx_width_gp'(axil_m_slot_addr_gp >> axil_base_addr_width_gp);
  logic [axil_slot_idx_width_gp-1:0] slot;
  logic [axil_base_addr_width_gp-1:0] ofs;
  assign slot = addr_i[axil_base_addr_width_gp +: axil_slot_idx_width_gp];
  assign ofs = addr_i[0 +: axil_base_addr_width_gp];
  for (genvar i = 0; i < num_fifos_p; i++) begin : h
    assign hit_o[i] = slot == base_slot_lp + axil_slot_idx_width_gp'(i);
  end
  assign ofs_o = ofs == axil_s2mm_ofs_rdfd_gp ? E_OFS_RDFD
               : ofs == axil_s2mm_ofs_rdfo_gp ? E_OFS_RDFO
               : ofs == axil_s2mm_ofs_rlr_gp  ? E_OFS_RLR
               : ofs == axil_s2mm_ofs_isr_gp  ? E_OFS_ISR
               : E_OFS_NONE;
endmodule

// File: rtl/bsg_axil_rxs.sv
// bsg_axil_rxs: AXI-Lite read responder that pops rx slot FIFOs on data-register reads.
// Define BSG_AXIL_RXS_ERR_ON_EMPTY_EN to answer empty data-register reads with SLVERR.
module bsg_axil_rxs
  import bsg_manycore_link_to_axil_pkg::*;
#(parameter int num_fifos_p = 0,
  parameter int occ_width_p = 10)
(
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [31:0]                            araddr_i,
  input  logic                                   arvalid_i,
  output logic                                   arready_o,
  output logic [31:0]                            rdata_o,
  output logic [1:0]                             rresp_o,
  output logic                                   rvalid_o,
  input  logic                                   rready_i,
  input  logic [num_fifos_p-1:0][31:0]           rxs_i,
  input  logic [num_fifos_p-1:0]                 rxs_v_i,
  output logic [num_fifos_p-1:0]                 rxs_yumi_o,
  input  logic [num_fifos_p-1:0][occ_width_p-1:0] rxs_occ_i,
  input  logic [num_fifos_p-1:0][31:0]           isrs_i
);
  rd_state_e state_r, state_n;
  rd_ofs_e ofs;
  logic [num_fifos_p-1:0] hit;
  logic [31:0] addr_r, word, isr, rdata_n;
  logic [occ_width_p-1:0] occ;
  logic [1:0] rresp_n;
  logic v, any_hit, empty_err;
  bsg_axil_rxs_decode #(.num_fifos_p(num_fifos_p)) dec (
    .addr_i(addr_r),
    .hit_o (hit),
    .ofs_o (ofs)
  );
  always_comb begin
    word = '0;
    isr = '0;
    occ = '0;
    v = 1'b0;
    for (int k = 0; k < num_fifos_p; k++) begin
      word = word | (rxs_i[k] & {32{hit[k]}});
      isr = isr | (isrs_i[k] & {32{hit[k]}});
      occ = occ | (rxs_occ_i[k] & {occ_width_p{hit[k]}});
      v = v | (rxs_v_i[k] & hit[k]);
    end
  end
  assign any_hit = |hit;
`ifdef BSG_AXIL_RXS_ERR_ON_EMPTY_EN
  assign empty_err = ofs == E_OFS_RDFD && !v;
`else
  assign empty_err = 1'b0;
`endif
  assign rdata_n = !any_hit           ? '0
                 : ofs == E_OFS_RDFD ? (v ? word : '0)
                 : ofs == E_OFS_RDFO ? 32'(occ)
                 : ofs == E_OFS_RLR  ? (v ? 32'd4 : '0)
                 : ofs == E_OFS_ISR  ? isr
                 : '0;
  assign rresp_n = !any_hit ? 2'b11 : empty_err ? 2'b10 : 2'b00;
  always_ff @(posedge clk_i)
    if (reset_i) state_r <= E_RD_IDLE;
    else state_r <= state_n;
  always_comb begin
    state_n = state_r == E_RD_IDLE ? (arvalid_i ? E_RD_ADDR : E_RD_IDLE)
            : state_r == E_RD_ADDR ? E_RD_DATA
            : state_r == E_RD_DATA ? E_RD_RESP
            : (rready_i ? E_RD_IDLE : E_RD_RESP);
    arready_o = state_r == E_RD_ADDR;
    rvalid_o = state_r == E_RD_RESP;
    // hit is one-hot, so at most one slot pops; a reset in this cycle cancels it
    rxs_yumi_o = (state_r == E_RD_DATA && ofs == E_OFS_RDFD && !reset_i) ? hit & rxs_v_i : '0;
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      addr_r <= '0;
      rdata_o <= '0;
      rresp_o <= '0;
    end else begin
      if (state_r == E_RD_ADDR) addr_r <= araddr_i;
      if (state_r == E_RD_DATA) begin
        rdata_o <= rdata_n;
        rresp_o <= rresp_n;
      end
    end
endmodule

// File: tb/tb_bsg_axil_rxs.sv
// tb_bsg_axil_rxs: directed read transactions against bsg_axil_rxs with two rx slots.
module tb_bsg_axil_rxs;
  localparam int nf = 2;
  localparam int ow = 10;
`ifdef BSG_AXIL_RXS_ERR_ON_EMPTY_EN
  localparam logic [1:0] empty_resp = 2'b10;
`else
  localparam logic [1:0] empty_resp = 2'b00;
`endif
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [31:0] araddr_i = '0;
  logic arvalid_i = 1'b0;
  logic arready_o;
  logic [31:0] rdata_o;
  logic [1:0] rresp_o;
  logic rvalid_o;
  logic rready_i = 1'b0;
  logic [nf-1:0][31:0] rxs_i = '0;
  logic [nf-1:0] rxs_v_i = '0;
  logic [nf-1:0] rxs_yumi_o;
  logic [nf-1:0][ow-1:0] rxs_occ_i = '0;
  logic [nf-1:0][31:0] isrs_i = '0;
  int checks = 0;
  int failures = 0;
  always #5 clk_i = ~clk_i;
  bsg_axil_rxs #(.num_fifos_p(nf), .occ_width_p(ow)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .rxs_i(rxs_i), .rxs_v_i(rxs_v_i), .rxs_yumi_o(rxs_yumi_o),
    .rxs_occ_i(rxs_occ_i), .isrs_i(isrs_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] ed,
                    input logic [1:0] er, input logic [nf-1:0] ey, input int hold, input bit mut);
    int ar_at = -1;
    int rv_at = -1;
    int held = 0;
    int ycnt = 0;
    int multi = 0;
    logic [nf-1:0] yor = '0;
    bit done = 1'b0;
    araddr_i = a;
    arvalid_i = 1'b1;
    rready_i = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk_i);
      if (arready_o && ar_at < 0) begin
        ar_at = c;
        arvalid_i = 1'b0;
      end
      if (rxs_yumi_o != '0) ycnt++;
      if ($countones(rxs_yumi_o) > 1) multi++;
      yor = yor | rxs_yumi_o;
      if (rready_i) begin
        done = 1'b1;
        rready_i = 1'b0;
        check($sformatf("%s_rvalid_drop", tag), 32'(rvalid_o), 32'd0);
      end else if (rvalid_o) begin
        if (rv_at < 0) rv_at = c;
        check($sformatf("%s_rdata", tag), rdata_o, ed);
        check($sformatf("%s_rresp", tag), 32'(rresp_o), 32'(er));
        if (held < hold) begin
          held++;
          if (mut) begin
            rxs_i[0] = $urandom;
            rxs_v_i[0] = ~rxs_v_i[0];
          end
        end else rready_i = 1'b1;
      end
    end
    arvalid_i = 1'b0;
    check($sformatf("%s_done", tag), 32'(done), 32'd1);
    check($sformatf("%s_ar_lat", tag), 32'(ar_at), 32'd1);
    check($sformatf("%s_rv_lat", tag), 32'(rv_at), 32'd3);
    check($sformatf("%s_yumi_bits", tag), 32'(yor), 32'(ey));
    check($sformatf("%s_yumi_cycles", tag), 32'(ycnt), 32'(ey != '0));
    check($sformatf("%s_yumi_onehot", tag), 32'(multi), 32'd0);
  endtask
  initial begin
    bit seen = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_arready", 32'(arready_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rresp", 32'(rresp_o), 32'd0);
    check("rst_yumi", 32'(rxs_yumi_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    rxs_i[0] = 32'hCAFE0001;
    rxs_v_i = 2'b01;
    rd("rdfd0", 32'h1020, 32'hCAFE0001, 2'b00, 2'b01, 0, 1'b0);
    rxs_i[1] = 32'hBEEF0002;
    rxs_v_i = 2'b11;
    rxs_occ_i[1] = 10'd5;
    isrs_i[1] = 32'h0000_0010;
    rd("rdfo1", 32'h201C, 32'd5, 2'b00, 2'b00, 0, 1'b0);
    rd("rlr1", 32'h2024, 32'd4, 2'b00, 2'b00, 0, 1'b0);
    rd("isr1", 32'h2000, 32'h10, 2'b00, 2'b00, 0, 1'b0);
    rd("rdfd1", 32'h2020, 32'hBEEF0002, 2'b00, 2'b10, 0, 1'b0);
    rd("badofs", 32'h1004, 32'd0, 2'b00, 2'b00, 0, 1'b0);
    rd("decerr", 32'h9020, 32'd0, 2'b11, 2'b00, 0, 1'b0);
    @(negedge clk_i);
    check("decerr_idle_arready", 32'(arready_o), 32'd0);
    check("decerr_idle_rvalid", 32'(rvalid_o), 32'd0);
    rxs_v_i = 2'b10;
    rd("empty0", 32'h1020, 32'd0, empty_resp, 2'b00, 0, 1'b0);
    rd("rlr_empty0", 32'h1024, 32'd0, 2'b00, 2'b00, 0, 1'b0);
    rxs_i[0] = 32'h12345678;
    rxs_v_i = 2'b01;
    rd("hold", 32'h1020, 32'h12345678, 2'b00, 2'b01, 6, 1'b1);
    rxs_i[0] = 32'hA5A5_0003;
    rxs_v_i = 2'b01;
    araddr_i = 32'h1020;
    arvalid_i = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (arready_o) seen = 1'b1;
    end
    arvalid_i = 1'b0;
    check("rst_mid_ar_seen", 32'(seen), 32'd1);
    @(negedge clk_i);
    check("rst_mid_pre_yumi", 32'(rxs_yumi_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check("rst_mid_yumi_now", 32'(rxs_yumi_o), 32'd0);
    @(negedge clk_i);
    check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_mid_arready", 32'(arready_o), 32'd0);
    check("rst_mid_yumi", 32'(rxs_yumi_o), 32'd0);
    check("rst_mid_rdata", rdata_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
    rd("after_rst", 32'h1020, 32'hA5A5_0003, 2'b00, 2'b01, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
